udp_status_tx: RTL
==================

# udp_status_tx

Transmit-side companion of the UDP command receiver. It snapshots a 64-bit status word and sends it as a fixed 8-byte UDP payload through the UDP stack's application TX interface. Bytes go most-significant first, matching the receiver's byte-to-field mapping: byte 0 = [63:56] … byte 7 = [7:0]. Transmission is triggered on demand by `send_req`, periodically by an internal timer, or both.

## Interface
Parameters:
- PERIOD_CYCLES, 125_000_000: auto-send interval in udp_rx_clk cycles; 0 disables the periodic trigger.
- ACK_TIMEOUT, 1024: cycles to wait in REQ for app_tx_ack before abandoning the frame; must be ≥1.

Ports:
- udp_rx_clk  in  1  clock; all logic is in this single domain.
- reset  in  1  asynchronous, active-low.
- status_data  in  64  payload source, sampled once per frame.
- send_req  in  1  software trigger; every cycle it is high registers a trigger.
- udp_tx_ready  in  1  stack is idle and able to accept a request.
- app_tx_ack  in  1  one-cycle grant from the stack for the pending request.
- app_tx_data_request  out  1  frame request, held until ack or timeout.
- app_tx_data_length  out  16  payload length, 16'd8 whenever requesting or sending.
- app_tx_data_valid  out  1  payload byte strobe.
- app_tx_data  out  8  payload byte.
- tx_busy  out  1  high in REQ or SEND.
- tx_done  out  1  one-cycle pulse after the last byte.
- tx_err  out  1  one-cycle pulse on ACK timeout.

## Operation
- pending flag:
  - Set by send_req = 1 or by a periodic-timer wrap.
  - Cleared on the IDLE→REQ transition.
  - Triggers arriving while pending is already set merge; at most one frame is queued.
  - A trigger in the same cycle as the IDLE→REQ clear leaves pending set.
- Periodic timer: 32-bit counter 0..PERIOD_CYCLES-1. On wrap it sets pending. It free-runs in every state and is not reset by send_req.
- FSM (registered state, 3 states):
  - IDLE: outputs quiet. If pending && udp_tx_ready → REQ, with app_tx_data_request=1, app_tx_data_length=8, ACK timer cleared.
  - REQ: app_tx_data_request held high.
    - If app_tx_ack → SEND. Load shift register ← status_data (snapshot taken in the ack cycle), byte_cnt ← 0, drop request.
    - Else if the ACK timer reaches ACK_TIMEOUT-1 → IDLE. Drop request, pulse tx_err; the frame is discarded and not retried unless re-triggered.
    - udp_tx_ready going low in REQ is ignored.
  - SEND: app_tx_data_valid=1 for exactly 8 consecutive cycles, with app_tx_data = shift register [63:56], shifting left 8 each cycle. A 3-bit byte_cnt runs 0..7. At byte_cnt==7 → IDLE, tx_done=1 in the following cycle, valid=0.
- status_data changes after the snapshot do not affect the frame in flight.
- app_tx_data is 0 whenever app_tx_data_valid=0.
- app_tx_data_length is 8 from REQ entry through the last byte, 0 in IDLE.
- send_req and ack arriving in the same cycle: the ack completes the current REQ, and send_req sets pending for the next frame.

## Timing
- All outputs are registered. Reset value of every output is 0, as are state=IDLE, pending=0, both timers=0, and the shift register.
- Reset assertion mid-frame:
  - All outputs drop immediately (asynchronous); the frame is aborted with no tx_done or tx_err.
  - After release, the block is in IDLE with nothing pending.
  - The periodic timer restarts from 0.
- Latency:
  - send_req high in cycle T with udp_tx_ready=1 in IDLE → pending at T+1, app_tx_data_request at T+2.
  - app_tx_ack in cycle A → first valid byte at A+1, last byte at A+8, tx_done at A+9.
- Minimum frame period: 10 cycles, measured from request rise to the next request rise when re-triggered during SEND.
- tx_busy is high from the first request cycle through the last valid byte inclusive.
- No valid gaps: the stack must accept one byte per cycle once it has acked.

## Test plan
- Single send: status_data=64'h0123_4567_89AB_CDEF, pulse send_req, ack after 3 request cycles → bytes 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles starting the cycle after ack; length=8 throughout; tx_done one cycle after EF.
- Snapshot: change status_data to all-ones in the cycle after ack → frame still carries the value present in the ack cycle.
- Merge: 3 send_req pulses during SEND → exactly one further frame, with request rising 2 cycles after the first frame's last byte; no third frame.
- Timeout (ACK_TIMEOUT=16): never ack → request high exactly 16 cycles, then tx_err pulse, IDLE; no valid bytes.
- Periodic (PERIOD_CYCLES=100, ack immediate) → a request every 100 cycles; holding udp_tx_ready low for 250 cycles produces one frame when it rises, not three.
- Reset mid-SEND after byte 3 → valid, request, and busy all 0 asynchronously; no tx_done; the next send after release starts again at byte 0.

Source files
------------

// File: rtl/udp_status_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_status_tx_if
// Description : Application TX handshake between the status transmitter and
//               the UDP stack.
//               master (transmitter): drives app_tx_data_request,
//                 app_tx_data_length, app_tx_data_valid, app_tx_data;
//                 samples udp_tx_ready, app_tx_ack.
//               slave (UDP stack): the reverse directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_status_tx_if;
  logic        udp_tx_ready;
  logic        app_tx_ack;
  logic        app_tx_data_request;
  logic [15:0] app_tx_data_length;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;

  modport master (
    input  udp_tx_ready,
    input  app_tx_ack,
    output app_tx_data_request,
    output app_tx_data_length,
    output app_tx_data_valid,
    output app_tx_data
  );

  modport slave (
    output udp_tx_ready,
    output app_tx_ack,
    input  app_tx_data_request,
    input  app_tx_data_length,
    input  app_tx_data_valid,
    input  app_tx_data
  );
endinterface
`default_nettype wire

// File: rtl/udp_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : udp_status_tx
// Description : Sends a 64-bit status snapshot as a fixed 8-byte UDP payload,
//               most-significant byte first. Frames are triggered by
//               send_req and/or an internal periodic timer; at most one
//               trigger is queued while a frame is in progress.
// Ports       : udp_rx_clk  - clock, single domain
//               reset       - asynchronous, active-low
//               status_data - payload source, captured in the ack cycle
//               send_req    - software trigger, level-sampled each cycle
//               app_tx      - UDP stack TX handshake (master side)
//               tx_busy     - high from first request cycle to last byte
//               tx_done     - one-cycle pulse after the last byte
//               tx_err      - one-cycle pulse when the ack wait times out
// Revision    : 1.0 - initial release
// ============================================================================
module udp_status_tx #(
  parameter int unsigned PERIOD_CYCLES = 125_000_000,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  wire              udp_rx_clk,
  input  wire              reset,
  input  wire  [63:0]      status_data,
  input  wire              send_req,
  udp_status_tx_if.master  app_tx,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_err
);

  localparam logic [15:0] c_PAYLOAD_LEN = 16'd8;
  localparam logic [31:0] c_ACK_LAST    = 32'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_pending;
  logic [31:0] r_ack_tmr;
  logic [55:0] r_shift;     // bytes still to send; the current one sits in app_tx_data
  logic [2:0]  r_byte_cnt;
  logic        w_tick;
  logic        w_start;

  // Periodic trigger: free-running in every state, only reset clears it.
  generate
    if (PERIOD_CYCLES > 0) begin : g_periodic
      localparam logic [31:0] c_PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
      logic [31:0] r_period_tmr;

      always_ff @(posedge udp_rx_clk or negedge reset) begin
        if (!reset) begin
          r_period_tmr <= '0;
        end else if (r_period_tmr == c_PERIOD_LAST) begin
          r_period_tmr <= '0;
        end else begin
          r_period_tmr <= r_period_tmr + 32'd1;
        end
      end

      assign w_tick = (r_period_tmr == c_PERIOD_LAST);
    end else begin : g_no_periodic
      assign w_tick = 1'b0;
    end
  endgenerate

  assign w_start = (r_state == ST_IDLE) && r_pending && app_tx.udp_tx_ready;

  // A trigger coinciding with the clear wins, so that request is not lost.
  always_ff @(posedge udp_rx_clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= (r_pending && !w_start) || send_req || w_tick;
    end
  end

  always_ff @(posedge udp_rx_clk or negedge reset) begin
    if (!reset) begin
      r_state                    <= ST_IDLE;
      r_ack_tmr                  <= '0;
      r_shift                    <= '0;
      r_byte_cnt                 <= '0;
      app_tx.app_tx_data_request <= 1'b0;
      app_tx.app_tx_data_length  <= '0;
      app_tx.app_tx_data_valid   <= 1'b0;
      app_tx.app_tx_data         <= '0;
      tx_busy                    <= 1'b0;
      tx_done                    <= 1'b0;
      tx_err                     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state                    <= ST_REQ;
            r_ack_tmr                  <= '0;
            app_tx.app_tx_data_request <= 1'b1;
            app_tx.app_tx_data_length  <= c_PAYLOAD_LEN;
            tx_busy                    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (app_tx.app_tx_ack) begin
            // First byte goes straight to the output register so it appears
            // the cycle after ack.
            r_state                    <= ST_SEND;
            app_tx.app_tx_data_request <= 1'b0;
            app_tx.app_tx_data_valid   <= 1'b1;
            app_tx.app_tx_data         <= status_data[63:56];
            r_shift                    <= status_data[55:0];
            r_byte_cnt                 <= '0;
          end else if (r_ack_tmr == c_ACK_LAST) begin
            r_state                    <= ST_IDLE;
            app_tx.app_tx_data_request <= 1'b0;
            app_tx.app_tx_data_length  <= '0;
            tx_busy                    <= 1'b0;
            tx_err                     <= 1'b1;
          end else begin
            r_ack_tmr <= r_ack_tmr + 32'd1;
          end
        end
        ST_SEND: begin
          if (r_byte_cnt == 3'd7) begin
            r_state                   <= ST_IDLE;
            app_tx.app_tx_data_valid  <= 1'b0;
            app_tx.app_tx_data        <= '0;
            app_tx.app_tx_data_length <= '0;
            tx_busy                   <= 1'b0;
            tx_done                   <= 1'b1;
          end else begin
            app_tx.app_tx_data <= r_shift[55:48];
            r_shift            <= {r_shift[47:0], 8'h00};
            r_byte_cnt         <= r_byte_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
